// File: rtl/multi_channel_memory_map.sv
// multi_channel_memory_map: MMIO register file plus per-channel go/busy/done control for NUM_CHANNELS DMA channels.
// Define MEMORY_MAP_CYCLE_COUNT_EN to add a saturating per-channel busy-cycle counter readable at offset +C.
module multi_channel_memory_map #(
    parameter int          ADDR_WIDTH   = 64,
    parameter int          SIZE_WIDTH   = 32,
    parameter int          NUM_CHANNELS = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h0050,
    parameter logic [15:0] GLOBAL_ADDR  = 16'h0040
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   mmio_wr_en,
    input  logic [15:0]                            mmio_wr_addr,
    input  logic [63:0]                            mmio_wr_data,
    input  logic                                   mmio_rd_en,
    input  logic [15:0]                            mmio_rd_addr,
    output logic [63:0]                            mmio_rd_data,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] wr_addr,
    output logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0] input_size,
    output logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0] output_size,
    output logic [NUM_CHANNELS-1:0]                go,
    input  logic [NUM_CHANNELS-1:0]                done
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q [NUM_CHANNELS];
    state_t state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0] input_size_q, input_size_d, output_size_q, output_size_d;
    logic [NUM_CHANNELS-1:0] go_q, go_d, sticky_q, sticky_d, busy, accept, fin, cfg_ok;
    logic [63:0] rd_data_q, rd_data_d, rd_mux;
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
    logic [NUM_CHANNELS-1:0][31:0] cnt_q, cnt_d;
`endif

    function automatic logic hit(logic [15:0] a, int c, int off);
        return a == BASE_ADDR + 16'(c * 16 + off);
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            busy[c]   = state_q[c] == BUSY;
            fin[c]    = busy[c] && done[c];
            cfg_ok[c] = mmio_wr_en && !busy[c];
            // A go may come from the channel's own register or from the global mask
            accept[c] = cfg_ok[c] && ((hit(mmio_wr_addr, c, 0) && mmio_wr_data[0]) ||
                        (mmio_wr_addr == GLOBAL_ADDR && mmio_wr_data[c]));
            go_d[c]          = accept[c];
            state_d[c]       = accept[c] ? BUSY : fin[c] ? IDLE : state_q[c];
            sticky_d[c]      = accept[c] ? 1'b0 : fin[c] ? 1'b1 : sticky_q[c];
            rd_addr_d[c]     = cfg_ok[c] && hit(mmio_wr_addr, c, 2) ? mmio_wr_data[ADDR_WIDTH-1:0] : rd_addr_q[c];
            wr_addr_d[c]     = cfg_ok[c] && hit(mmio_wr_addr, c, 4) ? mmio_wr_data[ADDR_WIDTH-1:0] : wr_addr_q[c];
            input_size_d[c]  = cfg_ok[c] && hit(mmio_wr_addr, c, 6) ? mmio_wr_data[SIZE_WIDTH-1:0] : input_size_q[c];
            output_size_d[c] = cfg_ok[c] && hit(mmio_wr_addr, c, 8) ? mmio_wr_data[SIZE_WIDTH-1:0] : output_size_q[c];
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
            cnt_d[c] = accept[c] ? 32'd0 : (busy[c] && cnt_q[c] != 32'hFFFF_FFFF) ? cnt_q[c] + 32'd1 : cnt_q[c];
`endif
        end
    end

    always_comb begin
        rd_mux = '0;
        if (mmio_rd_addr == GLOBAL_ADDR) rd_mux = {48'b0, 8'(busy), 8'(sticky_q)};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (hit(mmio_rd_addr, c, 2)) rd_mux = 64'(rd_addr_q[c]);
            if (hit(mmio_rd_addr, c, 4)) rd_mux = 64'(wr_addr_q[c]);
            if (hit(mmio_rd_addr, c, 6)) rd_mux = 64'(input_size_q[c]);
            if (hit(mmio_rd_addr, c, 8)) rd_mux = 64'(output_size_q[c]);
            if (hit(mmio_rd_addr, c, 10)) rd_mux = {62'b0, busy[c], sticky_q[c]};
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
            if (hit(mmio_rd_addr, c, 12)) rd_mux = 64'(cnt_q[c]);
`endif
        end
        rd_data_d = mmio_rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= '{default: IDLE};
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            input_size_q  <= '0;
            output_size_q <= '0;
            go_q          <= '0;
            sticky_q      <= '0;
            rd_data_q     <= '0;
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            input_size_q  <= input_size_d;
            output_size_q <= output_size_d;
            go_q          <= go_d;
            sticky_q      <= sticky_d;
            rd_data_q     <= rd_data_d;
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign rd_addr      = rd_addr_q;
    assign wr_addr      = wr_addr_q;
    assign input_size   = input_size_q;
    assign output_size  = output_size_q;
    assign go           = go_q;
    assign mmio_rd_data = rd_data_q;
endmodule

// File: tb/tb_multi_channel_memory_map.sv
// tb_multi_channel_memory_map: directed table plus randomized traffic against a behavioural register-map model.
module tb_multi_channel_memory_map;
    localparam int          NC    = 4;
    localparam int          AW    = 64;
    localparam int          SW    = 32;
    localparam logic [15:0] BASE  = 16'h0050;
    localparam logic [15:0] GADDR = 16'h0040;
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
    localparam logic [63:0] CNT10 = 64'd10;
`else
    localparam logic [63:0] CNT10 = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst, wr_en, rd_en;
    logic [15:0] wa, ra;
    logic [63:0] wd, rdata;
    logic [NC-1:0][AW-1:0] rd_addr, wr_addr;
    logic [NC-1:0][SW-1:0] input_size, output_size;
    logic [NC-1:0] go, done;

    always #5 clk = ~clk;

    multi_channel_memory_map dut (
        .clk(clk), .rst(rst),
        .mmio_wr_en(wr_en), .mmio_wr_addr(wa), .mmio_wr_data(wd),
        .mmio_rd_en(rd_en), .mmio_rd_addr(ra), .mmio_rd_data(rdata),
        .rd_addr(rd_addr), .wr_addr(wr_addr), .input_size(input_size), .output_size(output_size),
        .go(go), .done(done)
    );

    typedef struct {
        logic rst, we;
        logic [15:0] wa;
        logic [63:0] wd;
        logic re;
        logic [15:0] ra;
        logic [NC-1:0] dn, ego;
        logic [63:0] erd;
        logic chk;
    } vec_t;

    logic [NC-1:0] m_busy, m_sticky, m_go;
    logic [AW-1:0] m_rd [NC];
    logic [AW-1:0] m_wr [NC];
    logic [SW-1:0] m_in [NC];
    logic [SW-1:0] m_out [NC];
    logic [31:0] m_cnt [NC];
    logic [63:0] m_rdata;
    int n_vec = 0, n_err = 0;

    function automatic vec_t mk(logic r, logic we, logic [15:0] a, logic [63:0] d, logic re, logic [15:0] b,
                                logic [NC-1:0] dn, logic [NC-1:0] ego, logic [63:0] erd, logic chk);
        vec_t v;
        v.rst = r; v.we = we; v.wa = a; v.wd = d; v.re = re; v.ra = b;
        v.dn = dn; v.ego = ego; v.erd = erd; v.chk = chk;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_read(logic [15:0] a);
        int d = int'(a) - int'(BASE);
        int c, off;
        if (a == GADDR) return {48'b0, 8'(m_busy), 8'(m_sticky)};
        if (d < 0 || d >= NC * 16) return 64'd0;
        c = d / 16;
        off = d % 16;
        case (off)
            2: return 64'(m_rd[c]);
            4: return 64'(m_wr[c]);
            6: return 64'(m_in[c]);
            8: return 64'(m_out[c]);
            10: return {62'b0, m_busy[c], m_sticky[c]};
`ifdef MEMORY_MAP_CYCLE_COUNT_EN
            12: return 64'(m_cnt[c]);
`endif
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_step(vec_t v);
        logic [NC-1:0] ob = m_busy;
        int d, c;
        if (v.rst) begin
            m_busy = '0; m_sticky = '0; m_go = '0; m_rdata = '0;
            for (int i = 0; i < NC; i++) begin
                m_rd[i] = '0; m_wr[i] = '0; m_in[i] = '0; m_out[i] = '0; m_cnt[i] = '0;
            end
            return;
        end
        if (v.re) m_rdata = model_read(v.ra);
        m_go = '0;
        d = int'(v.wa) - int'(BASE);
        if (v.we && v.wa == GADDR) m_go = v.wd[NC-1:0] & ~ob;
        else if (v.we && d >= 0 && d < NC * 16 && !ob[d / 16]) begin
            c = d / 16;
            case (d % 16)
                0: m_go[c] = v.wd[0];
                2: m_rd[c] = v.wd[AW-1:0];
                4: m_wr[c] = v.wd[AW-1:0];
                6: m_in[c] = v.wd[SW-1:0];
                8: m_out[c] = v.wd[SW-1:0];
                default: ;
            endcase
        end
        for (int i = 0; i < NC; i++) begin
            if (ob[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i]++;
            if (ob[i] && v.dn[i]) begin
                m_busy[i] = 1'b0; m_sticky[i] = 1'b1;
            end else if (m_go[i]) begin
                m_busy[i] = 1'b1; m_sticky[i] = 1'b0; m_cnt[i] = '0;
            end
        end
    endtask

    task automatic apply(vec_t v, string tag);
        rst = v.rst; wr_en = v.we; wa = v.wa; wd = v.wd; rd_en = v.re; ra = v.ra; done = v.dn;
        @(posedge clk);
        #1;
        model_step(v);
        check({tag, " go"}, 64'(go), 64'(m_go));
        check({tag, " rd_data"}, rdata, m_rdata);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s rd_addr[%0d]", tag, c), 64'(rd_addr[c]), 64'(m_rd[c]));
            check($sformatf("%s wr_addr[%0d]", tag, c), 64'(wr_addr[c]), 64'(m_wr[c]));
            check($sformatf("%s input_size[%0d]", tag, c), 64'(input_size[c]), 64'(m_in[c]));
            check($sformatf("%s output_size[%0d]", tag, c), 64'(output_size[c]), 64'(m_out[c]));
        end
        if (v.chk) begin
            check({tag, " exp go"}, 64'(go), 64'(v.ego));
            check({tag, " exp rd_data"}, rdata, v.erd);
        end
    endtask

    function automatic logic [15:0] pick_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return GADDR;
        if (r == 1) return 16'($urandom);
        return BASE + 16'($urandom_range(0, NC) * 16 + $urandom_range(0, 7) * 2 + int'($urandom_range(0, 7) == 0));
    endfunction

    vec_t tbl [$];
    vec_t rv;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wa = '0; ra = '0; wd = '0; done = '0;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 16'h50, 1, 0, 0, 0, 4'b0001, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h5A, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0001, 0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h5A, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 16'h62, 64'h1000, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 16'h66, 16, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h62, 0, 0, 64'h1000, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h66, 0, 0, 16, 1));
        tbl.push_back(mk(0, 1, 16'h52, 64'h5555, 0, 0, 0, 0, 16, 1));
        tbl.push_back(mk(0, 1, 16'h50, 1, 0, 0, 0, 4'b0001, 16, 1));
        tbl.push_back(mk(0, 1, 16'h52, 64'hDEAD, 1, 16'h52, 0, 0, 64'h5555, 1));
        tbl.push_back(mk(0, 1, 16'h50, 1, 0, 0, 0, 0, 64'h5555, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h52, 0, 0, 64'h5555, 1));
        tbl.push_back(mk(0, 1, 16'h50, 1, 0, 0, 4'b0001, 0, 64'h5555, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h5A, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'hA0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 16'h40, 5, 0, 0, 0, 4'b0101, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h40, 0, 0, 64'h0500, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0101, 0, 64'h0500, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h40, 0, 0, 64'h0005, 1));
        tbl.push_back(mk(0, 1, 16'h68, 64'h77, 1, 16'h68, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h68, 0, 0, 64'h77, 1));
        tbl.push_back(mk(0, 1, 16'h40, 64'hF0, 1, 16'h6E, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 16'h90, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 16'h5A, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 16'h50, 2, 0, 0, 0, 0, 1, 1));
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Busy-cycle counter: go, ten BUSY edges with done on the tenth
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "cnt rst");
        apply(mk(0, 1, 16'h50, 1, 0, 0, 0, 4'b0001, 0, 1), "cnt go");
        repeat (9) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "cnt busy");
        apply(mk(0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 1), "cnt done");
        apply(mk(0, 0, 0, 0, 1, 16'h5C, 0, 0, CNT10, 1), "cnt read");

        // Reset in the middle of a transfer abandons it without a go pulse
        apply(mk(0, 1, 16'h62, 64'hABC, 0, 0, 0, 0, CNT10, 1), "mid cfg");
        apply(mk(0, 1, 16'h60, 1, 0, 0, 0, 4'b0010, CNT10, 1), "mid go");
        apply(mk(0, 0, 0, 0, 1, 16'h6A, 0, 0, 2, 1), "mid status");
        apply(mk(1, 1, 16'h60, 1, 1, 16'h62, 0, 0, 0, 1), "mid rst");
        apply(mk(0, 0, 0, 0, 1, 16'h6A, 0, 0, 0, 1), "mid status after");

        for (int i = 0; i < 600; i++) begin
            rv.rst = $urandom_range(0, 63) == 0;
            rv.we  = $urandom_range(0, 2) != 0;
            rv.wa  = pick_addr();
            rv.wd  = {$urandom, $urandom};
            rv.re  = $urandom_range(0, 2) != 0;
            rv.ra  = pick_addr();
            for (int c = 0; c < NC; c++) rv.dn[c] = $urandom_range(0, 7) == 0;
            rv.ego = '0; rv.erd = '0; rv.chk = 1'b0;
            apply(rv, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
